pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / flush / freeze controller.
// Generates the stage register write enables and bubble-insertion flushes
// from hazard-unit stall requests, branch mispredicts and data-memory waits.
// Optional feature macro: STALL_PERF_EN adds saturating stall_cycles and
// flush_count event counters (ports and logic absent when undefined).
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  hazard_stall,
    input  logic        br_flush,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
`ifdef STALL_PERF_EN
    output logic        stall_active,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`else
    output logic        stall_active
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    // cnt_r holds the number of bubbles still owed, including the current
    // STALL cycle; saved_r remembers RUN/STALL while the pipe is frozen.
    state_t     state_r;
    state_t     saved_r;
    logic [1:0] cnt_r;
    logic       pend_r;

    state_t     state_nxt_s;
    state_t     saved_nxt_s;
    state_t     eff_state_s;
    logic [1:0] cnt_nxt_s;
    logic       pend_nxt_s;
    logic       flush_apply_s;

    // State, bubble count, saved state and pending flush registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
            saved_r <= ST_RUN;
            cnt_r   <= 2'd0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            saved_r <= saved_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pend_r  <= pend_nxt_s;
        end
    end

    // Next-state and output decode, priority: memory wait, flush, stall, new hazard.
    always_comb begin
        state_nxt_s   = state_r;
        saved_nxt_s   = saved_r;
        cnt_nxt_s     = cnt_r;
        pend_nxt_s    = pend_r;
        flush_apply_s = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        stall_active  = 1'b0;
        eff_state_s   = (state_r == ST_FREEZE) ? saved_r : state_r;

        if (reset) begin
            // Idle outputs while reset is held, regardless of requests.
            state_nxt_s = ST_RUN;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            state_nxt_s  = ST_FREEZE;
            pend_nxt_s   = pend_r | br_flush;
            if (state_r != ST_FREEZE) begin
                saved_nxt_s = state_r;
            end else begin
                saved_nxt_s = saved_r;
            end
        end else if (br_flush || pend_r) begin
            // Wrong-path squash; any owed bubbles are cancelled.
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            flush_apply_s = 1'b1;
            state_nxt_s   = ST_RUN;
            saved_nxt_s   = ST_RUN;
            cnt_nxt_s     = 2'd0;
            pend_nxt_s    = 1'b0;
        end else begin
            case (eff_state_s)
                ST_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_flush  = 1'b1;
                    stall_active = 1'b1;
                    if (cnt_r > 2'd1) begin
                        state_nxt_s = ST_STALL;
                        cnt_nxt_s   = cnt_r - 2'd1;
                    end else begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = 2'd0;
                    end
                end
                ST_RUN: begin
                    if (hazard_stall != 2'd0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_flush  = 1'b1;
                        stall_active = 1'b1;
                        if (hazard_stall == 2'd1) begin
                            state_nxt_s = ST_RUN;
                            cnt_nxt_s   = 2'd0;
                        end else begin
                            // Requests of 2 and 3 both owe one more bubble.
                            state_nxt_s = ST_STALL;
                            cnt_nxt_s   = 2'd1;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = 2'd0;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = 2'd0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_count_r;

    // Saturating event counters for stall bubbles and applied flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 32'd0;
        end else begin
            if (stall_active && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (flush_apply_s && (flush_count_r != 32'hFFFF_FFFF)) begin
                flush_count_r <= flush_count_r + 32'd1;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, compared against a bubble-count reference model.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  hazard_stall;
    logic        br_flush;
    logic        mem_busy;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        stall_active;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int vectors;
    int miscompares;

    // Reference model: bubbles still owed, pending flush, event totals.
    int m_left;
    bit m_pend;
    int m_stalls;
    int m_flushes;

    // Output vector {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, stall}.
    localparam logic [6:0] O_NORMAL = 7'b1111000;
    localparam logic [6:0] O_BUBBLE = 7'b0011011;
    localparam logic [6:0] O_FLUSH  = 7'b1111110;
    localparam logic [6:0] O_FREEZE = 7'b0000000;

    pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .hazard_stall (hazard_stall),
        .br_flush     (br_flush),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_write  (id_ex_write),
        .ex_mem_write (ex_mem_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
`ifdef STALL_PERF_EN
        .stall_active (stall_active),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`else
        .stall_active (stall_active)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, stall_active};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef STALL_PERF_EN
        check({tag, "_stall_cycles"}, stall_cycles, m_stalls);
        check({tag, "_flush_count"}, flush_count, m_flushes);
`endif
    endtask

    task automatic model_reset();
        m_left    = 0;
        m_pend    = 1'b0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // One clock cycle: drive, predict, compare mid-cycle, advance.
    task automatic step(input string tag, input logic [1:0] hs, input logic br, input logic mb);
        logic [6:0] exp;
        hazard_stall = hs;
        br_flush     = br;
        mem_busy     = mb;
        #2;
        if (mb) begin
            exp    = O_FREEZE;
            m_pend = m_pend | br;
        end else if (br || m_pend) begin
            exp    = O_FLUSH;
            m_left = 0;
            m_pend = 1'b0;
            m_flushes++;
        end else if (m_left > 0) begin
            exp = O_BUBBLE;
            m_left--;
            m_stalls++;
        end else if (hs != 2'd0) begin
            exp    = O_BUBBLE;
            m_left = (hs == 2'd1) ? 0 : 1;
            m_stalls++;
        end else begin
            exp = O_NORMAL;
        end
        check(tag, {25'd0, outs()}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle with current inputs left in place.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_idle"}, {25'd0, outs()}, {25'd0, O_NORMAL});
        check_counters(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        hazard_stall = 2'd3;
        br_flush     = 1'b1;
        mem_busy     = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outs", {25'd0, outs()}, {25'd0, O_NORMAL});
        check_counters("reset");
        hazard_stall = 2'd0;
        br_flush     = 1'b0;
        reset        = 1'b0;

        // Idle run.
        for (int i = 0; i < 5; i++) step("idle", 2'd0, 1'b0, 1'b0);
        check_counters("idle");

        // Single-cycle stall.
        step("hs1_bubble", 2'd1, 1'b0, 1'b0);
        step("hs1_after", 2'd0, 1'b0, 1'b0);
        check_counters("hs1");

        // Two-cycle stall; request of 3 behaves as 2 and is ignored while stalling.
        model_reset();
        async_reset("pre_hs2");
        step("hs2_b1", 2'd2, 1'b0, 1'b0);
        step("hs2_b2", 2'd3, 1'b0, 1'b0);
        step("hs2_after", 2'd0, 1'b0, 1'b0);
        check_counters("hs2");
        step("hs3_b1", 2'd3, 1'b0, 1'b0);
        step("hs3_b2", 2'd0, 1'b0, 1'b0);
        step("hs3_after", 2'd0, 1'b0, 1'b0);

        // Branch flush in the second bubble cycle.
        async_reset("pre_flush");
        step("fl_b1", 2'd2, 1'b0, 1'b0);
        step("fl_flush", 2'd0, 1'b1, 1'b0);
        step("fl_after", 2'd0, 1'b0, 1'b0);
        check_counters("flush");

        // Freeze after first bubble with a flush pulse inside; bubble cancelled.
        step("fz_b1", 2'd2, 1'b0, 1'b0);
        step("fz_m1", 2'd0, 1'b0, 1'b1);
        step("fz_m2", 2'd1, 1'b1, 1'b1);
        step("fz_m3", 2'd0, 1'b0, 1'b1);
        step("fz_flush", 2'd0, 1'b0, 1'b0);
        step("fz_after", 2'd0, 1'b0, 1'b0);
        check_counters("freeze_flush");

        // Freeze mid-stall without flush resumes the owed bubble once.
        step("fr_b1", 2'd2, 1'b0, 1'b0);
        step("fr_m1", 2'd0, 1'b0, 1'b1);
        step("fr_m2", 2'd0, 1'b0, 1'b1);
        step("fr_b2", 2'd0, 1'b0, 1'b0);
        step("fr_after", 2'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-stall discards the remaining bubble.
        step("rs_b1", 2'd2, 1'b0, 1'b0);
        hazard_stall = 2'd0;
        async_reset("rs_mid");
        step("rs_after1", 2'd0, 1'b0, 1'b0);
        step("rs_after2", 2'd0, 1'b0, 1'b0);

        // Reset mid-freeze discards the pending flush.
        step("rz_m1", 2'd0, 1'b1, 1'b1);
        async_reset("rz_mid");
        step("rz_after", 2'd0, 1'b0, 1'b0);
        check_counters("rz");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] hs;
            logic       br;
            logic       mb;
            hs = ($urandom_range(0, 99) < 30) ? 2'($urandom_range(1, 3)) : 2'd0;
            br = ($urandom_range(0, 99) < 10);
            mb = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 2) begin
                async_reset("rnd_reset");
            end else begin
                step("rnd", hs, br, mb);
            end
            if ((i % 50) == 49) check_counters("rnd");
        end
        step("final", 2'd0, 1'b0, 1'b0);
        check_counters("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
